// File: rtl/axi_merge_w.sv
// Write-combining bridge: merges narrow single-beat AXI writes into one line buffer
// and writes the line out as a fixed-length wide INCR burst.
module axi_merge_w #(
    parameter int unsigned C_M_AXI_BURST_LEN  = 16,
    parameter int unsigned C_M_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 48,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    output logic                            busy,
    output logic                            wr_err,
    // Slave (narrow) write port
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [C_M_AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    // Master (wide) write port
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [7:0]                      m_axi_awlen,
    output logic [2:0]                      m_axi_awsize,
    output logic [1:0]                      m_axi_awburst,
    output logic                            m_axi_awlock,
    output logic [3:0]                      m_axi_awcache,
    output logic [2:0]                      m_axi_awprot,
    output logic [3:0]                      m_axi_awqos,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wlast,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready
);

    localparam int unsigned LineBytes = C_M_AXI_BURST_LEN * C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned SBytes    = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned MBytes    = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned Words     = LineBytes / SBytes;
    localparam int unsigned OffW      = $clog2(LineBytes);
    localparam int unsigned SLog      = $clog2(SBytes);
    localparam int unsigned BeatW     = (C_M_AXI_BURST_LEN > 1) ? $clog2(C_M_AXI_BURST_LEN) : 1;
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] OffMask = C_M_AXI_ADDR_WIDTH'(LineBytes - 1);

    typedef enum logic [1:0] {StCollect, StSendAw, StSendW, StWaitB} state_e;

    state_e                                    state_q, state_d;
    logic [Words-1:0][C_S_AXI_DATA_WIDTH-1:0]  line_q;
    logic [Words-1:0][SBytes-1:0]              mask_q;
    logic [C_M_AXI_BURST_LEN-1:0][C_M_AXI_DATA_WIDTH-1:0] line_beats;
    logic [C_M_AXI_BURST_LEN-1:0][MBytes-1:0]  mask_beats;
    logic [C_M_AXI_ADDR_WIDTH-1:0]             base_q;
    logic [BeatW-1:0]                          beat_q;
    logic                                      bvalid_q;
    logic                                      wr_err_q;

    logic             line_empty, line_full, addr_hit, slv_ready, accept, last_beat, w_fire;
    logic [OffW-SLog-1:0] word_idx;
    logic             unused_inputs;

    assign line_empty = ~|mask_q;
    assign line_full  = &mask_q;
    assign addr_hit   = (s_axi_awaddr & ~OffMask) == base_q;
    assign word_idx   = s_axi_awaddr[OffW-1:SLog];
    assign accept     = slv_ready & s_axi_awvalid & s_axi_wvalid;
    assign last_beat  = beat_q == BeatW'(C_M_AXI_BURST_LEN - 1);
    assign w_fire     = m_axi_wvalid & m_axi_wready;
    assign line_beats = line_q;
    assign mask_beats = mask_q;

    assign unused_inputs = ^{m_axi_bid, s_axi_awaddr[SLog-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StCollect;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCollect: begin
                // A miss with a pending write forces the current line out first.
                if (!line_empty && ((s_axi_awvalid && !addr_hit) || flush || line_full)) begin
                    state_d = StSendAw;
                end
            end
            StSendAw: if (m_axi_awready) state_d = StSendW;
            StSendW:  if (m_axi_wready && last_beat) state_d = StWaitB;
            StWaitB:  if (m_axi_bvalid) state_d = StCollect;
            default:  state_d = StCollect;
        endcase
    end

    always_comb begin
        slv_ready     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        unique case (state_q)
            StCollect: slv_ready     = !bvalid_q && (line_empty || addr_hit);
            StSendAw:  m_axi_awvalid = 1'b1;
            StSendW:   m_axi_wvalid  = 1'b1;
            StWaitB:   m_axi_bready  = 1'b1;
            default:   slv_ready     = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q   <= '0;
            base_q   <= '0;
            beat_q   <= '0;
            bvalid_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < int'(SBytes); i++) begin
                    if (s_axi_wstrb[i]) mask_q[word_idx][i] <= 1'b1;
                end
                if (line_empty) base_q <= s_axi_awaddr & ~OffMask;
                bvalid_q <= 1'b1;
            end else if (bvalid_q && s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
            if (w_fire) beat_q <= last_beat ? '0 : beat_q + 1'b1;
            if (state_q == StWaitB && m_axi_bvalid) begin
                mask_q <= '0;
                if (m_axi_bresp != 2'b00) wr_err_q <= 1'b1;
            end
        end
    end

    // Data bytes are qualified by mask_q, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < int'(SBytes); i++) begin
                if (s_axi_wstrb[i]) line_q[word_idx][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
            end
        end
    end

    assign s_axi_awready = slv_ready;
    assign s_axi_wready  = slv_ready;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_bid     = '0;

    assign m_axi_awaddr  = base_q;
    assign m_axi_awid    = '0;
    assign m_axi_awlen   = 8'(C_M_AXI_BURST_LEN - 1);
    assign m_axi_awsize  = 3'($clog2(MBytes));
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0010;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_wdata   = line_beats[beat_q];
    assign m_axi_wstrb   = mask_beats[beat_q];
    assign m_axi_wlast   = last_beat;

    assign busy   = !line_empty || (state_q != StCollect);
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_axi_merge_w.sv
// Directed bench for axi_merge_w: narrow writes in, wide bursts checked beat by beat.
module tb_axi_merge_w;

    localparam int AW = 48;
    localparam int SW = 32;
    localparam int MW = 256;
    localparam int LEN = 16;
    localparam int LIMIT = 200;

    logic clk = 1'b0;
    logic rst, flush, busy, wr_err;
    logic [AW-1:0] s_axi_awaddr;
    logic s_axi_awvalid, s_axi_awready;
    logic [SW-1:0] s_axi_wdata;
    logic [SW/8-1:0] s_axi_wstrb;
    logic s_axi_wvalid, s_axi_wready;
    logic [0:0] s_axi_bid;
    logic [1:0] s_axi_bresp;
    logic s_axi_bvalid, s_axi_bready;
    logic [AW-1:0] m_axi_awaddr;
    logic m_axi_awvalid, m_axi_awready;
    logic [0:0] m_axi_awid;
    logic [7:0] m_axi_awlen;
    logic [2:0] m_axi_awsize;
    logic [1:0] m_axi_awburst;
    logic m_axi_awlock;
    logic [3:0] m_axi_awcache;
    logic [2:0] m_axi_awprot;
    logic [3:0] m_axi_awqos;
    logic [MW-1:0] m_axi_wdata;
    logic [MW/8-1:0] m_axi_wstrb;
    logic m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [0:0] m_axi_bid;
    logic [1:0] m_axi_bresp;
    logic m_axi_bvalid, m_axi_bready;

    int checks = 0;
    int errors = 0;
    logic [MW-1:0]   bd [LEN];
    logic [MW/8-1:0] bs [LEN];
    logic            bl [LEN];

    always #5 clk = ~clk;

    axi_merge_w dut (
        .clk(clk), .rst(rst), .flush(flush), .busy(busy), .wr_err(wr_err),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bid(s_axi_bid),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
        .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ack_slave_b();
        check("s_bvalid", MW'(s_axi_bvalid), MW'(1));
        check("s_bresp", MW'(s_axi_bresp), MW'(0));
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        int n = 0;
        @(negedge clk);
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        #1;
        while (!s_axi_wready && n < LIMIT) begin
            @(negedge clk); #1; n++;
        end
        check("s_accept", MW'(s_axi_awready), MW'(1));
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        ack_slave_b();
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic master_aw(input logic [AW-1:0] exp_addr);
        int n = 0;
        while (!m_axi_awvalid && n < LIMIT) begin
            @(negedge clk); n++;
        end
        check("m_awvalid", MW'(m_axi_awvalid), MW'(1));
        check("m_awaddr", MW'(m_axi_awaddr), MW'(exp_addr));
        @(negedge clk);
        m_axi_awready = 1'b1;
        @(posedge clk); #1;
        m_axi_awready = 1'b0;
    endtask

    task automatic master_burst(input logic [AW-1:0] exp_addr, input logic [1:0] resp);
        master_aw(exp_addr);
        m_axi_wready = 1'b1;
        for (int k = 0; k < LEN; k++) begin
            int n = 0;
            while (!m_axi_wvalid && n < LIMIT) begin
                @(negedge clk); n++;
            end
            if (!m_axi_wvalid) check("m_wvalid", MW'(m_axi_wvalid), MW'(1));
            bd[k] = m_axi_wdata; bs[k] = m_axi_wstrb; bl[k] = m_axi_wlast;
            @(posedge clk); #1;
        end
        m_axi_wready = 1'b0;
        check("m_bready", MW'(m_axi_bready), MW'(1));
        check("m_wvalid_done", MW'(m_axi_wvalid), MW'(0));
        m_axi_bvalid = 1'b1; m_axi_bresp = resp;
        @(posedge clk); #1;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bid = '0; m_axi_bresp = 2'b00;
        m_axi_bvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_busy", MW'(busy), MW'(0));
        check("rst_wr_err", MW'(wr_err), MW'(0));
        check("rst_m_awvalid", MW'(m_axi_awvalid), MW'(0));
        check("rst_m_wvalid", MW'(m_axi_wvalid), MW'(0));
        check("rst_m_bready", MW'(m_axi_bready), MW'(0));
        check("rst_s_bvalid", MW'(s_axi_bvalid), MW'(0));
        check("rst_s_awready", MW'(s_axi_awready), MW'(1));

        // Flush of an empty line does nothing.
        pulse_flush();
        @(posedge clk); #1;
        check("empty_flush_busy", MW'(busy), MW'(0));
        check("empty_flush_awvalid", MW'(m_axi_awvalid), MW'(0));

        // Two words then flush: single burst, only beat 0 has strobes.
        do_write(48'h1000, 32'h0000000A, 4'hF);
        do_write(48'h1004, 32'h0000000B, 4'hF);
        check("busy_filled", MW'(busy), MW'(1));
        pulse_flush();
        check("awlen", MW'(m_axi_awlen), MW'(15));
        check("awsize", MW'(m_axi_awsize), MW'(5));
        check("awburst", MW'(m_axi_awburst), MW'(1));
        check("awcache", MW'(m_axi_awcache), MW'(2));
        master_burst(48'h1000, 2'b00);
        check("b0_strb", MW'(bs[0]), MW'(32'h000000FF));
        check("b0_data", MW'(bd[0][63:0]), MW'(64'h0000000B_0000000A));
        check("b0_last", MW'(bl[0]), MW'(0));
        check("b15_last", MW'(bl[15]), MW'(1));
        for (int k = 1; k < LEN; k++) check($sformatf("zero_strb%0d", k), MW'(bs[k]), MW'(0));
        check("busy_idle", MW'(busy), MW'(0));
        check("wr_err_ok", MW'(wr_err), MW'(0));

        // Miss stalls until the old line's B, then starts a new line.
        do_write(48'h1000, 32'h00000077, 4'hF);
        @(negedge clk);
        s_axi_awaddr = 48'h1200; s_axi_wdata = 32'h00000055; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        #1;
        check("miss_stall", MW'(s_axi_awready), MW'(0));
        master_burst(48'h1000, 2'b00);
        check("miss_old_data", MW'(bd[0][31:0]), MW'(32'h77));
        check("miss_release", MW'(s_axi_awready), MW'(1));
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        ack_slave_b();
        pulse_flush();
        master_burst(48'h1200, 2'b00);
        check("miss_new_data", MW'(bd[0][31:0]), MW'(32'h55));
        check("miss_new_strb", MW'(bs[0]), MW'(32'h0000000F));

        // Full line triggers a burst on its own.
        for (int i = 0; i < 128; i++) do_write(48'h2000 + 48'(4 * i), 32'h2000 + 32'(4 * i), 4'hF);
        master_burst(48'h2000, 2'b00);
        for (int k = 0; k < LEN; k++) check($sformatf("full_strb%0d", k), MW'(bs[k]), {MW{1'b0}} | 32'hFFFFFFFF);
        check("full_b0", MW'(bd[0][63:0]), MW'(64'h00002004_00002000));
        check("full_b15", MW'(bd[15][255:224]), MW'(32'h000021FC));

        // Byte merge plus error response.
        do_write(48'h1000, 32'h00001111, 4'h3);
        do_write(48'h1000, 32'h22220000, 4'hC);
        pulse_flush();
        master_burst(48'h1000, 2'b10);
        check("merge_data", MW'(bd[0][31:0]), MW'(32'h22221111));
        check("merge_strb", MW'(bs[0][3:0]), MW'(4'hF));
        check("wr_err_set", MW'(wr_err), MW'(1));
        do_write(48'h3000, 32'h1, 4'hF);
        pulse_flush();
        master_burst(48'h3000, 2'b00);
        check("wr_err_sticky", MW'(wr_err), MW'(1));

        // Reset in the middle of a burst.
        do_write(48'h4000, 32'hABCD, 4'hF);
        pulse_flush();
        master_aw(48'h4000);
        m_axi_wready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mid_wvalid", MW'(m_axi_wvalid), MW'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; m_axi_wready = 1'b0;
        check("mid_rst_wvalid", MW'(m_axi_wvalid), MW'(0));
        check("mid_rst_busy", MW'(busy), MW'(0));
        check("mid_rst_wr_err", MW'(wr_err), MW'(0));
        check("mid_rst_awready", MW'(s_axi_awready), MW'(1));
        do_write(48'h5004, 32'h5A5A5A5A, 4'hF);
        pulse_flush();
        master_burst(48'h5000, 2'b00);
        check("post_rst_data", MW'(bd[0][63:32]), MW'(32'h5A5A5A5A));
        check("post_rst_strb", MW'(bs[0]), MW'(32'h000000F0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_merge_w.md
AXI_MERGE_W -- requirements
Module: axi_merge_w

Interface
REQ-001 SHALL have parameter C_M_AXI_BURST_LEN, default 16, the number of beats in every master write burst.
REQ-002 SHALL have parameter C_M_AXI_ID_WIDTH, default 1, the ID width on both ports.
REQ-003 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 48, the address width on both ports.
REQ-004 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, the slave (narrow) data width.
REQ-005 SHALL have parameter C_M_AXI_DATA_WIDTH, default 256, the master (wide) data width; LINE_BYTES = C_M_AXI_BURST_LEN*C_M_AXI_DATA_WIDTH/8 (512 by default).
REQ-006 SHALL have ports as follows (clock and reset first); one clock; reset is synchronous and active-high:
  clk  in  1  sole clock, all logic on rising edge
  rst  in  1  synchronous active-high reset
  flush  in  1  pulse: write out the current line if it is non-empty
  busy  out  1  high while the line buffer is non-empty or a master burst is in flight
  wr_err  out  1  sticky: a master B response other than OKAY was received
  s_axi_awaddr/awvalid/awready  in/in/out  ADDR/1/1  slave write address (awid, awlen, awsize, awburst ignored; single beats only)
  s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  S_DW/S_DW/8/1/1  slave write data (wlast ignored)
  s_axi_bid/bresp/bvalid/bready  out/out/out/in  ID/2/1/1  slave write response
  m_axi_awaddr/awvalid/awready  out/out/in  ADDR/1/1  master burst address
  m_axi_awid/awlen/awsize/awburst/awlock/awcache/awprot/awqos  out  ID/8/3/2/1/4/3/4  constants 0, BURST_LEN-1, clog2(M_DW/8), 2'b01, 0, 4'b0010, 0, 0
  m_axi_wdata/wstrb/wlast/wvalid/wready  out/out/out/out/in  M_DW/M_DW/8/1/1/1  master write data
  m_axi_bid/bresp/bvalid/bready  in/in/in/out  ID/2/1/1  master write response

Function
REQ-007 SHALL hold a line buffer of LINE_BYTES data bytes, a per-byte valid mask, and line_base = awaddr & ~(LINE_BYTES-1).
REQ-008 SHALL use states COLLECT, SEND_AW, SEND_W, WAIT_B; reset state COLLECT.
REQ-009 SHALL drive s_axi_awready and s_axi_wready identically: high only in COLLECT, with s_axi_bvalid low, and with the line empty or the pending address hitting line_base.
REQ-010 SHALL accept a slave write only on a cycle where awvalid, wvalid, awready and wready are all high.
REQ-011 SHALL on acceptance merge wdata bytes enabled by wstrb into the line at byte offset (awaddr mod LINE_BYTES) aligned down to S_DW/8, set the matching mask bits, and load line_base if the line was empty.
REQ-012 SHALL assert s_axi_bvalid with bresp=0 and bid=0 the cycle after acceptance and hold it until s_axi_bready.
REQ-013 SHALL leave COLLECT for SEND_AW on the next cycle when any of: pending valid address misses a non-empty line; flush high with a non-empty line; mask all ones.
REQ-014 SHALL treat flush with an empty line as a no-op (busy stays low).
REQ-015 SHALL in SEND_AW drive m_axi_awaddr=line_base, m_axi_awvalid=1, stay until awready, then enter SEND_W.
REQ-016 SHALL in SEND_W emit exactly C_M_AXI_BURST_LEN beats, beat k carrying line bytes [k*M_DW/8 +: M_DW/8] and wstrb = matching mask slice (all-zero slices still sent), wlast on beat BURST_LEN-1, beat counter advances only on wvalid&wready.
REQ-017 SHALL after the last beat enter WAIT_B with m_axi_bready=1; on bvalid clear mask, set wr_err if bresp!=0, return to COLLECT.
REQ-018 SHALL never issue a new master burst before the previous B is received (one outstanding burst).
REQ-019 SHALL, when a miss triggered the flush, accept the missing write in COLLECT only after the clear, starting a new line.
REQ-020 SHALL have the offset computed modulo LINE_BYTES so lines never straddle a LINE_BYTES boundary.

Reset
REQ-021 SHALL on rst: state COLLECT, mask cleared, beat counter 0, all valid outputs (s_axi_bvalid, m_axi_awvalid, m_axi_wvalid) 0, m_axi_bready 0, wr_err 0, busy 0; buffered data discarded, including mid-burst.

Verification
REQ-022 Writes 0x1000=0xA, 0x1004=0xB, then flush -> one burst awaddr 0x1000, beat 0 wstrb=0x000000FF, beats 1..15 wstrb 0, two slave B OKAYs.
REQ-023 Write 0x1000, then 0x1200 -> second write stalled (awready low) until burst for 0x1000 gets B; then new line base 0x1200.
REQ-024 128 writes 0x2000..0x21FC all wstrb 0xF -> automatic burst at 0x2000, all wstrb all ones, no flush needed.
REQ-025 Two writes to 0x1000 with wstrb 0x3 (0x1111) then 0xC (0x2222) -> beat 0 data bits[31:0]=0x22221111, wstrb low nibble 0xF.
REQ-026 Master bresp=2'b10 on a burst -> wr_err rises and stays 1 until rst; slave bresp remains 0.
REQ-027 rst asserted during SEND_W beat 5 with wready held -> next cycle wvalid=0, busy=0, state COLLECT, subsequent write accepted.
